receptor_serial_comando: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) feeding the feeder controller's data path. Converts the `dadoSerial` line into a byte held in an output register, raises a level `pronto` flag until the consumer acknowledges with `ler`, and reports framing and overrun errors. Sits directly upstream of the command register and control unit that decode commands such as "open" (`abrir`).

---
 rtl/receptor_serial_comando.sv | 133 +++++++++++++
 tb/tb_receptor_serial_comando.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/receptor_serial_comando.sv
// 8N1 serial receiver (LSB first) for the feeder controller command path.
// Holds the last good byte in dado with a level pronto flag and sticky error flags.
module receptor_serial_comando #(
    parameter int DIVISOR      = 5208,
    parameter int LARGURA_CONT = $clog2(DIVISOR)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dadoSerial,
    input  logic       ler,
    output logic [7:0] dado,
    output logic       pronto,
    output logic       erroFrame,
    output logic       overrun,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL      = 3'd0,
        ESPERA       = 3'd1,
        START        = 3'd2,
        DADOS        = 3'd3,
        STOP         = 3'd4,
        ARMAZENA     = 3'd5,
        AGUARDA_ALTO = 3'd6
    } estado_t;

    localparam logic [LARGURA_CONT-1:0] MEIO_BIT = LARGURA_CONT'(DIVISOR / 2 - 1);
    localparam logic [LARGURA_CONT-1:0] FIM_BIT  = LARGURA_CONT'(DIVISOR - 1);

    estado_t                 estado_reg;
    logic [LARGURA_CONT-1:0] cont_reg;
    logic [2:0]              indice_reg;
    logic [7:0]              desloc_reg;
    logic [7:0]              dado_reg;
    logic                    pronto_reg;
    logic                    erro_frame_reg;
    logic                    overrun_reg;
    logic                    sinc_meta_reg;
    logic                    rx_s_reg;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_meta_reg <= 1'b1;
            rx_s_reg      <= 1'b1;
        end else begin
            sinc_meta_reg <= dadoSerial;
            rx_s_reg      <= sinc_meta_reg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg     <= INICIAL;
            cont_reg       <= '0;
            indice_reg     <= '0;
            desloc_reg     <= '0;
            dado_reg       <= '0;
            pronto_reg     <= 1'b0;
            erro_frame_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            // Acknowledge first so that a same-cycle store or error below takes precedence.
            if (ler) begin
                pronto_reg     <= 1'b0;
                erro_frame_reg <= 1'b0;
                overrun_reg    <= 1'b0;
            end
            case (estado_reg)
                INICIAL: estado_reg <= ESPERA;
                ESPERA: begin
                    if (!rx_s_reg) begin
                        estado_reg <= START;
                        cont_reg   <= '0;
                    end
                end
                START: begin
                    if (cont_reg == MEIO_BIT) begin
                        cont_reg   <= '0;
                        indice_reg <= '0;
                        estado_reg <= rx_s_reg ? ESPERA : DADOS;
                    end else begin
                        cont_reg <= cont_reg + 1'b1;
                    end
                end
                DADOS: begin
                    if (cont_reg == FIM_BIT) begin
                        cont_reg   <= '0;
                        desloc_reg <= {rx_s_reg, desloc_reg[7:1]};
                        indice_reg <= indice_reg + 1'b1;
                        if (indice_reg == 3'd7)
                            estado_reg <= STOP;
                    end else begin
                        cont_reg <= cont_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cont_reg == FIM_BIT) begin
                        cont_reg <= '0;
                        if (rx_s_reg) begin
                            estado_reg <= ARMAZENA;
                        end else begin
                            erro_frame_reg <= 1'b1;
                            estado_reg     <= AGUARDA_ALTO;
                        end
                    end else begin
                        cont_reg <= cont_reg + 1'b1;
                    end
                end
                ARMAZENA: begin
                    dado_reg   <= desloc_reg;
                    pronto_reg <= 1'b1;
                    if (pronto_reg && !ler)
                        overrun_reg <= 1'b1;
                    estado_reg <= ESPERA;
                end
                AGUARDA_ALTO: begin
                    if (rx_s_reg)
                        estado_reg <= ESPERA;
                end
                default: estado_reg <= INICIAL;
            endcase
        end
    end

    assign dado      = dado_reg;
    assign pronto    = pronto_reg;
    assign erroFrame = erro_frame_reg;
    assign overrun   = overrun_reg;
    assign db_estado = estado_reg;

endmodule

// File: tb/tb_receptor_serial_comando.sv
// Directed bench for receptor_serial_comando with DIVISOR=16: table-driven frames
// plus hand-written sequences for glitch, framing error, overrun and mid-frame reset.
module tb_receptor_serial_comando;

    localparam int DIV = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       dadoSerial;
    logic       ler;
    logic [7:0] dado;
    logic       pronto;
    logic       erroFrame;
    logic       overrun;
    logic [2:0] db_estado;

    int n_total = 0;
    int n_pass  = 0;

    receptor_serial_comando #(.DIVISOR(DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .dadoSerial (dadoSerial),
        .ler        (ler),
        .dado       (dado),
        .pronto     (pronto),
        .erroFrame  (erroFrame),
        .overrun    (overrun),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        int         idle;
        logic [7:0] exp_dado;
        logic       exp_pronto;
        logic       exp_ov;
    } vec_t;

    vec_t tab[5];

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", nome, got);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, exp);
        end
    endtask

    // Called at a negedge; start bit low from the next posedge, 16 cycles per bit.
    task automatic send_frame(input logic [7:0] d, input logic stopbit);
        logic [9:0] bits;
        bits = {stopbit, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            dadoSerial = bits[b];
            repeat (DIV) @(negedge clock);
        end
    endtask

    task automatic pulse_ler();
        ler = 1'b1;
        @(negedge clock);
        ler = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{8'h01, 0, 8'h01, 1'b1, 1'b0};
        tab[1] = '{8'h80, 0, 8'h80, 1'b1, 1'b0};
        tab[2] = '{8'hFF, 8, 8'hFF, 1'b1, 1'b0};
        tab[3] = '{8'h00, 4, 8'h00, 1'b1, 1'b0};
        tab[4] = '{8'hC3, 4, 8'hC3, 1'b1, 1'b0};

        reset = 1'b0; dadoSerial = 1'b1; ler = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_dado", dado, 8'h00);
        check("reset_pronto", pronto, 1'b0);
        check("reset_erroFrame", erroFrame, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_estado", db_estado, 3'd0);
        reset = 1'b1;
        @(negedge clock);
        check("inicial_to_espera", db_estado, 3'd1);
        repeat (3) @(negedge clock);

        // Single byte with exact pronto timing
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (155) @(negedge clock);
                check("t1_pronto_before_155", pronto, 1'b0);
                @(negedge clock);
                check("t1_pronto_at_155", pronto, 1'b1);
                check("t1_dado", dado, 8'h55);
                check("t1_erroFrame", erroFrame, 1'b0);
                check("t1_overrun", overrun, 1'b0);
            end
        join
        pulse_ler();
        check("t1_pronto_after_ler", pronto, 1'b0);
        repeat (4) @(negedge clock);

        // Glitch rejection
        dadoSerial = 1'b0;
        repeat (4) @(negedge clock);
        dadoSerial = 1'b1;
        repeat (2) @(negedge clock);
        check("glitch_in_start", db_estado, 3'd2);
        repeat (10) @(negedge clock);
        check("glitch_back_espera", db_estado, 3'd1);
        check("glitch_pronto", pronto, 1'b0);
        check("glitch_dado", dado, 8'h55);

        // Table: back-to-back 0x01, 0x80, 0xFF, then spaced frames, ack after each
        for (int i = 0; i < 5; i++) begin
            fork
                send_frame(tab[i].d, 1'b1);
                begin
                    repeat (157) @(negedge clock);
                    check($sformatf("tab%0d_pronto", i), pronto, tab[i].exp_pronto);
                    check($sformatf("tab%0d_dado", i), dado, tab[i].exp_dado);
                    check($sformatf("tab%0d_overrun", i), overrun, tab[i].exp_ov);
                    pulse_ler();
                    check($sformatf("tab%0d_pronto_acked", i), pronto, 1'b0);
                end
            join
            repeat (tab[i].idle) @(negedge clock);
        end

        // Framing error with line held low
        send_frame(8'hA3, 1'b0);
        repeat (40) @(negedge clock);
        check("frame_erroFrame", erroFrame, 1'b1);
        check("frame_pronto", pronto, 1'b0);
        check("frame_estado_low", db_estado, 3'd6);
        check("frame_dado_kept", dado, 8'hC3);
        dadoSerial = 1'b1;
        repeat (4) @(negedge clock);
        check("frame_estado_high", db_estado, 3'd1);
        check("frame_erroFrame_sticky", erroFrame, 1'b1);
        pulse_ler();
        check("frame_erroFrame_cleared", erroFrame, 1'b0);
        repeat (4) @(negedge clock);

        // Overrun without ack
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        check("ovr_dado", dado, 8'h34);
        check("ovr_overrun", overrun, 1'b1);
        check("ovr_pronto", pronto, 1'b1);
        pulse_ler();
        check("ovr_overrun_cleared", overrun, 1'b0);
        check("ovr_pronto_cleared", pronto, 1'b0);
        repeat (4) @(negedge clock);

        // Ack in the same cycle as the store: store wins, no overrun
        send_frame(8'h12, 1'b1);
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (155) @(negedge clock);
                check("simul_estado_armazena", db_estado, 3'd5);
                pulse_ler();
                check("simul_pronto", pronto, 1'b1);
                check("simul_dado", dado, 8'h34);
                check("simul_overrun", overrun, 1'b0);
            end
        join
        pulse_ler();
        repeat (4) @(negedge clock);

        // Reset during data bit 3 of 0xFF, with a pending byte beforehand
        send_frame(8'h5A, 1'b1);
        check("pre_reset_pronto", pronto, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (70) @(negedge clock);
                reset = 1'b0;
                #1;
                check("midrst_dado", dado, 8'h00);
                check("midrst_pronto", pronto, 1'b0);
                check("midrst_erroFrame", erroFrame, 1'b0);
                check("midrst_overrun", overrun, 1'b0);
                check("midrst_estado", db_estado, 3'd0);
                repeat (20) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check("midrst_release_espera", db_estado, 3'd1);
            end
        join
        repeat (4) @(negedge clock);
        send_frame(8'h0F, 1'b1);
        check("postrst_dado", dado, 8'h0F);
        check("postrst_pronto", pronto, 1'b1);
        check("postrst_erroFrame", erroFrame, 1'b0);
        check("postrst_overrun", overrun, 1'b0);
        pulse_ler();
        check("postrst_pronto_cleared", pronto, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
